// File: rtl/cga_attrib_pal_if.sv
// Palette configuration bus for cga_attrib_pal: live lookup enable plus a
// single-cycle write strobe with index and data.
interface cga_attrib_pal_if #(
  parameter int PIX_W = 4
);
  logic             pal_en;
  logic             pal_wr;
  logic [3:0]       pal_addr;
  logic [PIX_W-1:0] pal_data;

  modport master (output pal_en, pal_wr, pal_addr, pal_data);
  modport slave  (input  pal_en, pal_wr, pal_addr, pal_data);
endinterface

// File: rtl/cga_attrib_pal.sv
// CGA attribute/pixel resolver: stage 1 forms a 4-bit colour index and blank
// flag, stage 2 maps it through a writable palette; syncs delayed to match.
module cga_attrib_pal #(
  parameter int PIX_W          = 4,
  parameter int BLINK_DIV      = 2,
  parameter bit PAL_BYPASS_RST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic [7:0]       att_byte,
  input  logic [7:0]       cga_color_reg,
  input  logic             bw_mode,
  input  logic             blink_enabled,
  input  logic             display_enable,
  input  logic             cursor,
  input  logic             blink,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             pix_in,
  input  logic             c0,
  input  logic             c1,
  input  logic             pix_640,
  input  logic [3:0]       pix_16,
  cga_attrib_pal_if.slave  pal_bus,
  output logic [PIX_W-1:0] pix_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             de_out
);

  typedef enum logic [1:0] {
    MODE_TEXT  = 2'b00,
    MODE_GFX4  = 2'b01,
    MODE_GFX2  = 2'b10,
    MODE_GFX16 = 2'b11
  } mode_e;

  // Blink divider: blink_sync[1:0] synchronise, blink_sync[2] holds the previous value.
  logic [2:0] blink_sync;
  logic [3:0] blink_cnt;
  logic       blinkdiv;
  logic       blink_rise;

  assign blink_rise = blink_sync[1] & ~blink_sync[2];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_sync <= '0;
      blink_cnt  <= '0;
      blinkdiv   <= 1'b0;
    end else begin
      blink_sync <= {blink_sync[1:0], blink};
      if (blink_rise) begin
        if (blink_cnt == 4'(BLINK_DIV - 1)) begin
          blink_cnt <= '0;
          blinkdiv  <= ~blinkdiv;
        end else begin
          blink_cnt <= blink_cnt + 4'd1;
        end
      end
    end
  end

  logic [3:0] gfx_idx;
  logic [3:0] idx_d;
  logic       blank_d;
  logic       alpha;

  assign gfx_idx = {cga_color_reg[4], c1, c0, bw_mode ? c0 : cga_color_reg[5]};
  assign blank_d = hsync | vsync | ((mode == MODE_GFX2) & ~(display_enable & pix_640));

  always_comb begin
    // NOTE: defaults first, so no branch leaves idx_d unassigned and infers a latch.
    idx_d = cga_color_reg[3:0];
    alpha = (pix_in & (~(blink_enabled & att_byte[7] & ~cursor) | ~blinkdiv)) | (cursor & blink);
    if (display_enable) begin
      unique case (mode_e'(mode))
        MODE_TEXT:  idx_d = alpha ? att_byte[3:0]
                                  : (blink_enabled ? {1'b0, att_byte[6:4]} : att_byte[7:4]);
        MODE_GFX4:  if (c0 | c1) idx_d = gfx_idx;
        MODE_GFX2:  idx_d = gfx_idx;
        MODE_GFX16: idx_d = pix_16;
      endcase
    end
  end

  logic [3:0] idx_s1;
  logic       blank_s1, hs_s1, vs_s1, de_s1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_s1   <= '0;
      blank_s1 <= 1'b1;
      hs_s1    <= 1'b0;
      vs_s1    <= 1'b0;
      de_s1    <= 1'b0;
    end else begin
      idx_s1   <= idx_d;
      blank_s1 <= blank_d;
      hs_s1    <= hsync;
      vs_s1    <= vsync;
      de_s1    <= display_enable;
    end
  end

  // Palette: identity after reset; the stage-2 read below sees the pre-write entry.
  logic [PIX_W-1:0] pal_mem [16];

  // NOTE: the palette has a defined reset image, so it is built from resettable flops, not RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) pal_mem[i] <= PIX_W'(i);
    end else if (pal_bus.pal_wr) begin
      pal_mem[pal_bus.pal_addr] <= pal_bus.pal_data;
    end
  end

  // Stage 2 keeps the looked-up and raw values plus the enable sampled at this edge.
  logic [PIX_W-1:0] pal_rd;
  logic [3:0]       idx_s2;
  logic             blank_s2, pal_en_s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pal_rd    <= '0;
      idx_s2    <= '0;
      blank_s2  <= 1'b1;
      pal_en_s2 <= ~PAL_BYPASS_RST;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      de_out    <= 1'b0;
    end else begin
      pal_rd    <= pal_mem[idx_s1];
      idx_s2    <= idx_s1;
      blank_s2  <= blank_s1;
      pal_en_s2 <= pal_bus.pal_en;
      hsync_out <= hs_s1;
      vsync_out <= vs_s1;
      de_out    <= de_s1;
    end
  end

  assign pix_out = blank_s2 ? '0 : (pal_en_s2 ? pal_rd : PIX_W'(idx_s2));

endmodule

// File: tb/tb_cga_attrib_pal.sv
// Self-checking bench for cga_attrib_pal: an edge-counting behavioural model
// compared every cycle, plus directed vectors with hand-computed pixels.
module tb_cga_attrib_pal;
  localparam int PIX_W     = 8;
  localparam int BLINK_DIV = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] mode = '0;
  logic [7:0] att_byte = '0, cga_color_reg = '0;
  logic bw_mode = 0, blink_enabled = 0, display_enable = 0, cursor = 0, blink = 0;
  logic hsync = 0, vsync = 0, pix_in = 0, c0 = 0, c1 = 0, pix_640 = 0;
  logic [3:0] pix_16 = '0;
  logic [PIX_W-1:0] pix_out;
  logic hsync_out, vsync_out, de_out;

  cga_attrib_pal_if #(.PIX_W(PIX_W)) pal_bus ();

  cga_attrib_pal #(.PIX_W(PIX_W), .BLINK_DIV(BLINK_DIV), .PAL_BYPASS_RST(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .att_byte(att_byte),
    .cga_color_reg(cga_color_reg), .bw_mode(bw_mode), .blink_enabled(blink_enabled),
    .display_enable(display_enable), .cursor(cursor), .blink(blink),
    .hsync(hsync), .vsync(vsync), .pix_in(pix_in), .c0(c0), .c1(c1),
    .pix_640(pix_640), .pix_16(pix_16), .pal_bus(pal_bus.slave),
    .pix_out(pix_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       blank;
    logic [3:0] idx;
    logic       hs, vs, de;
  } pix_t;

  pix_t             m_s1;
  logic [PIX_W-1:0] m_pal [16];
  int               m_edges;
  logic             h1, h2, h3;
  logic [PIX_W-1:0] exp_pix;
  logic             exp_hs, exp_vs, exp_de;

  function automatic pix_t resolve(input logic bdiv);
    pix_t r;
    logic hidden, shown;
    logic [3:0] gfx;
    r.hs    = hsync;
    r.vs    = vsync;
    r.de    = display_enable;
    r.blank = hsync || vsync || (mode == 2'd2 && !(display_enable && pix_640));
    gfx     = {cga_color_reg[4], c1, c0, bw_mode ? c0 : cga_color_reg[5]};
    hidden  = blink_enabled && att_byte[7] && !cursor && bdiv;
    shown   = (pix_in && !hidden) || (cursor && blink);
    if (!display_enable) r.idx = cga_color_reg[3:0];
    else if (mode == 2'd0)
      r.idx = shown ? att_byte[3:0] : (blink_enabled ? {1'b0, att_byte[6:4]} : att_byte[7:4]);
    else if (mode == 2'd1) r.idx = (c0 || c1) ? gfx : cga_color_reg[3:0];
    else if (mode == 2'd2) r.idx = gfx;
    else r.idx = pix_16;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pal[i] = PIX_W'(i);
    m_s1 = '0;
    m_edges = 0;
    {h1, h2, h3} = 3'b000;
    exp_pix = '0;
    {exp_hs, exp_vs, exp_de} = 3'b000;
  endtask

  task automatic model_step();
    pix_t nxt;
    logic bdiv;
    bdiv = ((m_edges / BLINK_DIV) % 2) == 1;
    nxt  = resolve(bdiv);
    exp_pix = m_s1.blank ? '0 : (pal_bus.pal_en ? m_pal[m_s1.idx] : PIX_W'(m_s1.idx));
    exp_hs  = m_s1.hs;
    exp_vs  = m_s1.vs;
    exp_de  = m_s1.de;
    if (pal_bus.pal_wr) m_pal[pal_bus.pal_addr] = pal_bus.pal_data;
    m_s1 = nxt;
    if (h2 && !h3) m_edges++;
    h3 = h2;
    h2 = h1;
    h1 = blink;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    check("pix_out",   32'(pix_out), 32'(exp_pix));
    check("hsync_out", 32'(hsync_out), 32'(exp_hs));
    check("vsync_out", 32'(vsync_out), 32'(exp_vs));
    check("de_out",    32'(de_out), 32'(exp_de));
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic blink_pulse();
    blink = 1'b1;
    step(3);
    blink = 1'b0;
    step(3);
  endtask

  task automatic text_setup(input logic ben);
    mode = 2'd0; att_byte = 8'h9E; blink_enabled = ben; pix_in = 1'b1;
    cursor = 1'b0; display_enable = 1'b1; hsync = 1'b0; vsync = 1'b0;
  endtask

  initial begin
    pal_bus.pal_en = 1'b0; pal_bus.pal_wr = 1'b0;
    pal_bus.pal_addr = '0; pal_bus.pal_data = '0;

    // Reset held while inputs wiggle.
    for (int i = 0; i < 4; i++) begin
      mode = 2'($urandom); pix_16 = 4'($urandom); hsync = 1'b1; vsync = 1'($urandom);
      display_enable = 1'b1; pal_bus.pal_en = 1'($urandom);
      step(1);
    end
    check("rst_pix", 32'(pix_out), 32'h0);
    check("rst_hs",  32'(hsync_out), 32'h0);
    check("rst_de",  32'(de_out), 32'h0);

    // Release: 16-colour pixel 0xA through identity palette, 2 clocks later.
    reset_n = 1'b1; pal_bus.pal_en = 1'b1; mode = 2'd3; pix_16 = 4'hA;
    display_enable = 1'b1; hsync = 1'b0; vsync = 1'b0;
    step(1);
    check("lat_1clk", 32'(pix_out), 32'h0);
    step(1);
    check("lat_2clk", 32'(pix_out), 32'hA);

    // Text blink alternation.
    text_setup(1'b1);
    step(2);
    check("txt_fg0", 32'(pix_out), 32'hE);
    blink_pulse(); blink_pulse();
    check("txt_bg", 32'(pix_out), 32'h1);
    blink_pulse(); blink_pulse();
    check("txt_fg1", 32'(pix_out), 32'hE);
    text_setup(1'b0);
    blink_pulse();
    check("txt_noblink", 32'(pix_out), 32'hE);

    // Mid-frame async reset with the blink counter at 1.
    step(1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_pix", 32'(pix_out), 32'h0);
    check("arst_de",  32'(de_out), 32'h0);
    step(2);
    reset_n = 1'b1;
    text_setup(1'b1);
    pal_bus.pal_en = 1'b0;
    step(2);
    check("post_rst_fg", 32'(pix_out), 32'hE);
    blink_pulse();
    check("post_rst_1edge", 32'(pix_out), 32'hE);
    blink_pulse();
    check("post_rst_2edge", 32'(pix_out), 32'h1);

    // Palette write read-before-write.
    mode = 2'd3; pix_16 = 4'h3; pal_bus.pal_en = 1'b1;
    step(1);
    pal_bus.pal_wr = 1'b1; pal_bus.pal_addr = 4'h3; pal_bus.pal_data = 8'h2C;
    step(1);
    check("pal_old", 32'(pix_out), 32'h03);
    pal_bus.pal_wr = 1'b0;
    step(1);
    check("pal_new", 32'(pix_out), 32'h2C);
    pal_bus.pal_en = 1'b0;
    step(1);
    check("pal_bypass", 32'(pix_out), 32'h03);

    // 4-colour graphics.
    mode = 2'd1; cga_color_reg = 8'h30; bw_mode = 1'b0; c1 = 1'b1; c0 = 1'b0;
    step(2);
    check("gfx4_10", 32'(pix_out), 32'hD);
    c1 = 1'b0;
    step(2);
    check("gfx4_00", 32'(pix_out), 32'h0);
    bw_mode = 1'b1; c0 = 1'b1;
    step(2);
    check("gfx4_bw01", 32'(pix_out), 32'hB);

    // Blanking, 640 mode and overscan.
    mode = 2'd3; pix_16 = 4'h5; hsync = 1'b1;
    step(2);
    check("blank_hs_pix", 32'(pix_out), 32'h0);
    check("blank_hs_out", 32'(hsync_out), 32'h1);
    hsync = 1'b0; mode = 2'd2; pix_640 = 1'b0;
    step(2);
    check("gfx2_dark", 32'(pix_out), 32'h0);
    pix_640 = 1'b1; c1 = 1'b1; c0 = 1'b1;
    step(2);
    check("gfx2_lit", 32'(pix_out), 32'hF);
    mode = 2'd3; display_enable = 1'b0; cga_color_reg = 8'h37;
    step(2);
    check("overscan", 32'(pix_out), 32'h7);

    // Mixed traffic, checked every cycle by the model.
    for (int i = 0; i < 120; i++) begin
      mode = 2'($urandom); att_byte = 8'($urandom); cga_color_reg = 8'($urandom);
      bw_mode = 1'($urandom); blink_enabled = 1'($urandom);
      display_enable = ($urandom_range(0, 3) != 0); cursor = ($urandom_range(0, 3) == 0);
      blink = 1'($urandom); hsync = ($urandom_range(0, 7) == 0); vsync = ($urandom_range(0, 15) == 0);
      pix_in = 1'($urandom); c0 = 1'($urandom); c1 = 1'($urandom);
      pix_640 = 1'($urandom); pix_16 = 4'($urandom);
      pal_bus.pal_en = 1'($urandom); pal_bus.pal_wr = ($urandom_range(0, 3) == 0);
      pal_bus.pal_addr = 4'($urandom); pal_bus.pal_data = 8'($urandom);
      step(1);
    end
    pal_bus.pal_wr = 1'b0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cga_attrib_pal.md
Name: cga_attrib_pal

Overview:
- Parametrised successor to the CGA attribute resolver.
- Resolves one pixel per clock from the text attribute byte or the graphics pixel bits into a 4-bit logical colour index.
- Maps the index through a writable palette (Tandy/EGA-style) and drives a registered pixel output.
- Sits between the sequencer/shifter and the DAC/scan-doubler. Adds configurable blink division, a two-stage pipeline and delay-matched sync outputs.

Parameters:
- PIX_W, 4, output pixel width in bits (4..8); palette entry width.
- BLINK_DIV, 2, number of cursor-blink rising edges per character-blink toggle (1..15).
- PAL_BYPASS_RST, 1, reset value of pal_en inverted (1 = palette bypassed after reset).

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- mode  in  2  00 text, 01 graphics 4-colour, 10 graphics 2-colour (640), 11 graphics 16-colour
- att_byte  in  8  text attribute
- cga_color_reg  in  8  colour select register (bits 3:0 overscan, 4 intensity, 5 palette)
- bw_mode  in  1  selects c0 as blue bit in 4-colour mode
- blink_enabled  in  1  attribute bit 7 = blink, not background intensity
- display_enable  in  1  active area
- cursor  in  1  cursor cell
- blink  in  1  cursor blink square wave
- hsync, vsync  in  1  raw syncs
- pix_in  in  1  text glyph dot
- c0, c1  in  1  2-bit graphics pixel
- pix_640  in  1  640-mode dot
- pix_16  in  4  16-colour pixel
- pal_en  in  1  palette lookup enable
- pal_wr  in  1  palette write strobe
- pal_addr  in  4  palette write index
- pal_data  in  PIX_W  palette write data
- pix_out  out  PIX_W  resolved pixel
- hsync_out, vsync_out, de_out  out  1  syncs/enable delayed to match pix_out

Behaviour:
- Reset (async, reset_n low):
  - pix_out = 0; hsync_out, vsync_out and de_out = 0.
  - Blink edge counter = 0; blinkdiv = 0.
  - Palette entry i = i zero-extended to PIX_W.
  - pal_en is sampled live; PAL_BYPASS_RST only sets the internal enable latch's reset value.
- Blink divider:
  - blink is synchronised through 2 flops.
  - Each 0->1 edge increments the counter.
  - When counter reaches BLINK_DIV-1 on an edge: counter -> 0 and blinkdiv toggles.
  - Reset mid-count clears both.
- Stage 1 (registered), computes logical index idx and blank flag:
  - blank = hsync | vsync | (mode==10 & ~(display_enable & pix_640)).
  - ~display_enable, any mode: idx = cga_color_reg[3:0].
  - Text: alpha = (pix_in & (~(blink_enabled & att_byte[7] & ~cursor) | ~blinkdiv)) | (cursor & blink). alpha=1 -> fg = att_byte[3:0]; alpha=0 -> bg = blink_enabled ? {0, att_byte[6:4]} : att_byte[7:4].
  - 01: (c0|c1)=0 -> cga_color_reg[3:0]; else {cga_color_reg[4], c1, c0, bw_mode ? c0 : cga_color_reg[5]}.
  - 10: idx = {cga_color_reg[4], c1, c0, bw_mode ? c0 : cga_color_reg[5]}.
  - 11: idx = pix_16.
- Stage 2 (registered):
  - blank -> pix_out = 0.
  - Else pal_en -> pix_out = palette[idx]; else idx zero-extended (low PIX_W bits if PIX_W<4 is not allowed).
- Latency:
  - Inputs to pix_out: exactly 2 clocks.
  - hsync_out, vsync_out and de_out are delayed 2 clocks by the same registers.
- Palette write:
  - Single-cycle strobe, no handshake back-pressure; entry is updated at the clk edge where pal_wr=1.
  - Read in stage 2 of the same index on the same edge returns the old value (read-before-write); the new value is visible from the next cycle.
  - Writes are accepted regardless of display_enable.
- Mode change mid-line: takes effect on the pixel sampled that cycle; no glitch suppression.

Test Plan:
- Reset: hold reset_n=0, toggle inputs -> pix_out=0, syncs 0; release, pal_en=1, mode=11, pix_16=4'hA, display_enable=1 -> pix_out=0xA exactly 2 clocks later (identity palette).
- Text blink: att_byte=8'h9E, blink_enabled=1, pix_in=1, BLINK_DIV=2 -> pix_out alternates 0xE / bg 0x1 every 2 blink rising edges; blink_enabled=0 -> steady 0xE.
- Palette write: write pal_addr=3, pal_data=0x2C while idx=3 in stage 2 -> that pixel shows 0x03, next pixel 0x2C; pal_en=0 -> 0x03.
- 4-colour: mode=01, cga_color_reg=8'h30, c1c0=10 -> idx 0xD; c1c0=00 -> 0x0; bw_mode=1, c1c0=01 -> 0xB.
- Blanking: hsync=1 with any pixel -> pix_out=0 two clocks later and hsync_out=1 same cycle; mode=10, pix_640=0, display_enable=1 -> 0.
- Async reset asserted mid-frame with blink counter at 1 -> outputs 0 immediately; after release, first blinkdiv toggle needs a full BLINK_DIV edges.
